// File: rtl/ibex_rf_wb_pkg.sv
// Shared types and address helpers for the register-file writeback controller.
// Address decode honours RV32E (bit 4 ignored) and treats x0 as never written.
package ibex_rf_wb_pkg;

  localparam int unsigned RfAddrWidth = 5;
  localparam int unsigned RfDataWidth = 32;

  typedef struct packed {
    logic                   valid;
    logic [RfAddrWidth-1:0] addr;
    logic [RfDataWidth-1:0] data;
  } rf_wr_req_t;

  function automatic logic [RfAddrWidth-1:0] rf_addr_decode(logic [RfAddrWidth-1:0] addr,
                                                            logic                   rv32e);
    return rv32e ? {1'b0, addr[3:0]} : addr;
  endfunction

  function automatic logic rf_addr_is_x0(logic [RfAddrWidth-1:0] addr, logic rv32e);
    return rf_addr_decode(addr, rv32e) == '0;
  endfunction

  // x0 never matches, so it can neither be written nor forwarded.
  function automatic logic rf_addr_match(logic [RfAddrWidth-1:0] addr_a,
                                         logic [RfAddrWidth-1:0] addr_b,
                                         logic                   rv32e);
    return (rf_addr_decode(addr_a, rv32e) == rf_addr_decode(addr_b, rv32e)) &&
           !rf_addr_is_x0(addr_a, rv32e);
  endfunction

endpackage

// File: rtl/ibex_rf_fwd_mux.sv
// Read-after-write forwarding for one operand port: the skid buffer holds the
// younger write, so it takes precedence over the writeback stage.
module ibex_rf_fwd_mux
  import ibex_rf_wb_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic [4:0]           raddr,
  input  logic                 buf_valid,
  input  logic [4:0]           buf_addr,
  input  logic [DataWidth-1:0] buf_data,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_addr,
  input  logic [DataWidth-1:0] wb_data,
  output logic                 fwd_valid,
  output logic [DataWidth-1:0] fwd_data
);

  always_comb begin
    fwd_valid = 1'b0;
    fwd_data  = '0;
    if (buf_valid && rf_addr_match(buf_addr, raddr, RV32E)) begin
      fwd_valid = 1'b1;
      fwd_data  = buf_data;
    end else if (wb_valid && rf_addr_match(wb_addr, raddr, RV32E)) begin
      fwd_valid = 1'b1;
      fwd_data  = wb_data;
    end
  end

endmodule

// File: rtl/ibex_rf_wb_ctrl.sv
// Merges EX results and late LSU load responses into one registered RF write
// stream, with a one-entry EX skid buffer and operand forwarding.
// Optional IBEX_RF_WB_PERF_CNT_EN adds a saturating collision counter output.
module ibex_rf_wb_ctrl
  import ibex_rf_wb_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  input  logic                 flush_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_a_valid_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic                 fwd_b_valid_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic                 busy_o
`ifdef IBEX_RF_WB_PERF_CNT_EN
  ,
  output logic [31:0]          collision_cnt_o
`endif
);

  typedef struct packed {
    logic                 valid;
    logic [4:0]           addr;
    logic [DataWidth-1:0] data;
  } wb_entry_t;

  wb_entry_t wb_q, wb_d;
  wb_entry_t buf_q, buf_d;
  wb_entry_t sel;
  logic      ex_accept;
  logic      buf_live;
  logic      buf_load;

  assign ex_ready_o = ~buf_q.valid;
  assign ex_accept  = ex_valid_i & ~buf_q.valid & ~flush_i;
  // A flush kills the buffered entry before it can be selected for writeback.
  assign buf_live   = buf_q.valid & ~flush_i;
  assign buf_load   = lsu_valid_i & ex_accept;

  // Source select: LSU > skid buffer > accepted EX
  always_comb begin
    sel         = '0;
    buf_d       = buf_q;
    buf_d.valid = 1'b0;
    if (lsu_valid_i) begin
      sel = '{valid: 1'b1, addr: lsu_waddr_i, data: lsu_wdata_i};
      if (buf_load) begin
        buf_d = '{valid: 1'b1, addr: ex_waddr_i, data: ex_wdata_i};
      end else begin
        buf_d.valid = buf_live;
      end
    end else if (buf_live) begin
      sel = buf_q;
    end else if (ex_accept) begin
      sel = '{valid: 1'b1, addr: ex_waddr_i, data: ex_wdata_i};
    end
  end

  // x0 entries are consumed but issue no write; addr/data hold the last real write.
  always_comb begin
    wb_d       = wb_q;
    wb_d.valid = 1'b0;
    if (sel.valid && !rf_addr_is_x0(sel.addr, RV32E)) begin
      wb_d = sel;
    end
  end

  // Stage boundary: writeback register and skid buffer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_q  <= '0;
      buf_q <= '0;
    end else begin
      wb_q  <= wb_d;
      buf_q <= buf_d;
    end
  end

  assign rf_we_o    = wb_q.valid;
  assign rf_waddr_o = wb_q.addr;
  assign rf_wdata_o = wb_q.data;
  assign busy_o     = wb_q.valid | buf_q.valid;

  ibex_rf_fwd_mux #(
    .RV32E     (RV32E),
    .DataWidth (DataWidth)
  ) u_fwd_a (
    .raddr     (raddr_a_i),
    .buf_valid (buf_q.valid),
    .buf_addr  (buf_q.addr),
    .buf_data  (buf_q.data),
    .wb_valid  (wb_q.valid),
    .wb_addr   (wb_q.addr),
    .wb_data   (wb_q.data),
    .fwd_valid (fwd_a_valid_o),
    .fwd_data  (fwd_a_data_o)
  );

  ibex_rf_fwd_mux #(
    .RV32E     (RV32E),
    .DataWidth (DataWidth)
  ) u_fwd_b (
    .raddr     (raddr_b_i),
    .buf_valid (buf_q.valid),
    .buf_addr  (buf_q.addr),
    .buf_data  (buf_q.data),
    .wb_valid  (wb_q.valid),
    .wb_addr   (wb_q.addr),
    .wb_data   (wb_q.data),
    .fwd_valid (fwd_b_valid_o),
    .fwd_data  (fwd_b_data_o)
  );

`ifdef IBEX_RF_WB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

  logic [31:0] collision_cnt_q;

  // Stage boundary: collision counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      collision_cnt_q <= '0;
    end else if (buf_load) begin
      collision_cnt_q <= sat_inc32(collision_cnt_q);
    end
  end

  assign collision_cnt_o = collision_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_rf_wb_ctrl.sv
// Self-checking bench for ibex_rf_wb_ctrl: a queue-based write-order model plus
// directed literal checks, followed by randomized traffic.
module tb_ibex_rf_wb_ctrl;

  localparam int unsigned DW    = 32;
  localparam bit          RV32E = 1'b0;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ex_valid_i = 1'b0;
  logic          ex_ready_o;
  logic [4:0]    ex_waddr_i = '0;
  logic [DW-1:0] ex_wdata_i = '0;
  logic          lsu_valid_i = 1'b0;
  logic [4:0]    lsu_waddr_i = '0;
  logic [DW-1:0] lsu_wdata_i = '0;
  logic          flush_i = 1'b0;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic [4:0]    raddr_a_i = '0;
  logic [4:0]    raddr_b_i = '0;
  logic          fwd_a_valid_o, fwd_b_valid_o;
  logic [DW-1:0] fwd_a_data_o, fwd_b_data_o;
  logic          busy_o;

  always #5 clk = ~clk;

  ibex_rf_wb_ctrl #(
    .RV32E     (RV32E),
    .DataWidth (DW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .ex_waddr_i    (ex_waddr_i),
    .ex_wdata_i    (ex_wdata_i),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_waddr_i   (lsu_waddr_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .flush_i       (flush_i),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .raddr_a_i     (raddr_a_i),
    .raddr_b_i     (raddr_b_i),
    .fwd_a_valid_o (fwd_a_valid_o),
    .fwd_a_data_o  (fwd_a_data_o),
    .fwd_b_valid_o (fwd_b_valid_o),
    .fwd_b_data_o  (fwd_b_data_o),
    .busy_o        (busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending EX writes in program order, plus the write issued this cycle.
  typedef struct {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          pend[$];
  bit            m_wb_v;
  ent_t          m_wb;
  logic [4:0]    m_last_a;
  logic [DW-1:0] m_last_d;

  function automatic logic [4:0] dec(logic [4:0] a);
    logic [4:0] r;
    r = a;
    if (RV32E) r[4] = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_wb_v   = 1'b0;
    m_wb     = '{a: '0, d: '0};
    m_last_a = '0;
    m_last_d = '0;
  endtask

  task automatic model_fwd(input logic [4:0] r, output logic v, output logic [DW-1:0] d);
    v = 1'b0;
    d = '0;
    if (dec(r) == 5'd0) return;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (dec(pend[i].a) == dec(r)) begin
        v = 1'b1;
        d = pend[i].d;
        return;
      end
    end
    if (m_wb_v && dec(m_wb.a) == dec(r)) begin
      v = 1'b1;
      d = m_wb.d;
    end
  endtask

  task automatic model_step();
    bit   ready;
    bit   nv;
    ent_t n;
    ready = (pend.size() == 0);
    if (flush_i) pend.delete();
    if (ex_valid_i && ready && !flush_i) pend.push_back('{a: ex_waddr_i, d: ex_wdata_i});
    nv = 1'b0;
    n  = '{a: '0, d: '0};
    if (lsu_valid_i) begin
      nv = 1'b1;
      n  = '{a: lsu_waddr_i, d: lsu_wdata_i};
    end else if (pend.size() > 0) begin
      nv = 1'b1;
      n  = pend.pop_front();
    end
    m_wb_v = nv && (dec(n.a) != 5'd0);
    if (m_wb_v) begin
      m_wb     = n;
      m_last_a = n.a;
      m_last_d = n.d;
    end
  endtask

  task automatic compare();
    logic          fv;
    logic [DW-1:0] fd;
    chk("rf_we", rf_we_o, m_wb_v);
    chk("rf_waddr", rf_waddr_o, m_last_a);
    chk("rf_wdata", rf_wdata_o, m_last_d);
    chk("busy", busy_o, (m_wb_v || pend.size() > 0));
    chk("ex_ready", ex_ready_o, (pend.size() == 0));
    model_fwd(raddr_a_i, fv, fd);
    chk("fwd_a_valid", fwd_a_valid_o, fv);
    chk("fwd_a_data", fwd_a_data_o, fd);
    model_fwd(raddr_b_i, fv, fd);
    chk("fwd_b_valid", fwd_b_valid_o, fv);
    chk("fwd_b_data", fwd_b_data_o, fd);
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    if (rst_ni) model_step();
    #1;
  endtask

  task automatic step(input logic ev, input logic [4:0] ea, input logic [DW-1:0] ed,
                      input logic lv, input logic [4:0] la, input logic [DW-1:0] ld,
                      input logic fl);
    ex_valid_i  = ev;
    ex_waddr_i  = ea;
    ex_wdata_i  = ed;
    lsu_valid_i = lv;
    lsu_waddr_i = la;
    lsu_wdata_i = ld;
    flush_i     = fl;
    cycle();
  endtask

  task automatic idle();
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
  endtask

  initial begin
    model_reset();
    rst_ni = 1'b0;
    repeat (2) idle();
    chk("rst_we", rf_we_o, 0);
    chk("rst_waddr", rf_waddr_o, 0);
    chk("rst_wdata", rf_wdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ex_ready_o, 1);
    chk("rst_fwd_a", fwd_a_valid_o, 0);
    rst_ni = 1'b1;
    idle();

    // Single EX write
    step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0, 0);
    chk("single_we", rf_we_o, 1);
    chk("single_addr", rf_waddr_o, 5);
    chk("single_data", rf_wdata_o, 32'hDEADBEEF);
    idle();
    chk("single_we_off", rf_we_o, 0);

    // Collision: LSU first, buffered EX next
    step(1, 5'd3, 32'h22, 1, 5'd3, 32'h11, 0);
    chk("coll_w1_addr", rf_waddr_o, 3);
    chk("coll_w1_data", rf_wdata_o, 32'h11);
    chk("coll_ready0", ex_ready_o, 0);
    idle();
    chk("coll_w2_we", rf_we_o, 1);
    chk("coll_w2_data", rf_wdata_o, 32'h22);
    chk("coll_ready1", ex_ready_o, 1);
    idle();

    // LSU starvation of the buffered entry
    step(1, 5'd7, 32'h7, 1, 5'd1, 32'h101, 0);
    chk("starve_ready_a", ex_ready_o, 0);
    step(1, 5'd8, 32'h8, 1, 5'd2, 32'h102, 0);
    chk("starve_ready_b", ex_ready_o, 0);
    chk("starve_addr_b", rf_waddr_o, 2);
    step(0, 5'd0, 0, 1, 5'd9, 32'h103, 0);
    chk("starve_ready_c", ex_ready_o, 0);
    chk("starve_addr_c", rf_waddr_o, 9);
    idle();
    chk("starve_x7_we", rf_we_o, 1);
    chk("starve_x7_addr", rf_waddr_o, 7);
    chk("starve_x7_data", rf_wdata_o, 32'h7);
    chk("starve_ready_d", ex_ready_o, 1);
    idle();

    // Forwarding: buffer beats writeback stage; x0 never hits
    raddr_a_i = 5'd4;
    raddr_b_i = 5'd0;
    step(1, 5'd4, 32'hA, 1, 5'd4, 32'hB, 0);
    chk("fwd_wb_data", rf_wdata_o, 32'hB);
    chk("fwd_a_hit", fwd_a_valid_o, 1);
    chk("fwd_a_val", fwd_a_data_o, 32'hA);
    chk("fwd_b_x0", fwd_b_valid_o, 0);
    chk("fwd_b_zero", fwd_b_data_o, 0);
    idle();
    chk("fwd_a_after_drain", fwd_a_data_o, 32'hA);
    idle();

    // x0 write suppressed
    step(1, 5'd0, 32'hFF, 0, 5'd0, 0, 0);
    chk("x0_we", rf_we_o, 0);
    idle();

    // Flush drops the buffered entry
    step(1, 5'd10, 32'hAA, 1, 5'd6, 32'h66, 0);
    chk("flush_ready0", ex_ready_o, 0);
    step(0, 5'd0, 0, 0, 5'd0, 0, 1);
    chk("flush_ready1", ex_ready_o, 1);
    chk("flush_no_we", rf_we_o, 0);
    idle();
    chk("flush_no_we2", rf_we_o, 0);
    chk("flush_busy", busy_o, 0);

    // Flush with LSU: load still written, EX dropped
    step(1, 5'd11, 32'hBB, 1, 5'd12, 32'hCC, 1);
    chk("flush_lsu_addr", rf_waddr_o, 12);
    chk("flush_lsu_ready", ex_ready_o, 1);
    idle();
    chk("flush_lsu_no_ex", rf_we_o, 0);

    // Asynchronous reset with both entries valid
    step(1, 5'd2, 32'h6, 1, 5'd1, 32'h5, 0);
    chk("midrst_busy_pre", busy_o, 1);
    ex_valid_i  = 1'b0;
    lsu_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_we", rf_we_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", ex_ready_o, 1);
    model_reset();
    repeat (2) idle();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("midrst_no_we", rf_we_o, 0);
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      raddr_a_i = 5'($urandom_range(0, 7));
      raddr_b_i = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 19) == 0));
    end
    repeat (3) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_rf_wb_ctrl.md
Name: ibex_rf_wb_ctrl

Overview:
- Write-side initiator for the register file's single write port.
- Merges two writeback sources into one registered write stream (rf_we_o / rf_waddr_o / rf_wdata_o) that drives the register file write port directly:
  - ALU/EX results;
  - late load responses from the LSU.
- Holds one EX result in a skid buffer when both sources collide.
- Provides read-after-write forwarding for both operand read ports while writes are still pending.

Parameters:
- RV32E, 0: 1 = 16 registers; address bit 4 ignored for decode, match and forwarding.
- DataWidth, 32: width of write and forward data.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ex_valid_i  in  1  EX result valid
- ex_ready_o  out  1  EX result accepted this cycle
- ex_waddr_i  in  5  EX destination register
- ex_wdata_i  in  DataWidth  EX result data
- lsu_valid_i  in  1  load response valid; cannot be stalled
- lsu_waddr_i  in  5  load destination register
- lsu_wdata_i  in  DataWidth  load data
- flush_i  in  1  discard buffered/incoming EX result
- rf_we_o  out  1  register file write enable
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  DataWidth  register file write data
- raddr_a_i, raddr_b_i  in  5  operand read addresses
- fwd_a_valid_o, fwd_b_valid_o  out  1  forward hit
- fwd_a_data_o, fwd_b_data_o  out  DataWidth  forwarded data
- busy_o  out  1  any write pending (wb stage or buffer)

Behaviour:
- State:
  - wb stage register wb_q {valid, addr, data}, which drives the rf_* outputs;
  - skid buffer buf_q {valid, addr, data}.
- Reset: wb_q.valid = 0, buf_q.valid = 0, all data/addr = 0. Therefore rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, busy_o = 0, ex_ready_o = 1, fwd_*_valid_o = 0.
- ex_ready_o = !buf_q.valid (combinational). An EX result is accepted when ex_valid_i && ex_ready_o && !flush_i.
- Source selection each cycle, fixed priority: lsu_valid_i > buf_q > accepted EX.
  - The selected entry loads into wb_q at the next edge, giving 1-cycle latency from input to rf_we_o.
  - If nothing is selected, wb_q.valid <= 0.
- Collision: an EX result accepted in the same cycle as lsu_valid_i goes into buf_q. buf_q drains on the first cycle without lsu_valid_i.
- Ordering is decided: a load response always belongs to an instruction older than any pending EX result, so LSU-first priority preserves program order.
- x0: an entry whose decoded address is 0 is consumed normally, but wb_q.valid is loaded as 0, so no write is issued. The entry never forwards.
- rf_we_o = wb_q.valid, rf_waddr_o = wb_q.addr, rf_wdata_o = wb_q.data. All three are held at their last value when the stage is invalid.
- Forwarding per port (combinational):
  - hit if buf_q.valid && buf_q.addr == raddr, else if wb_q.valid && wb_q.addr == raddr;
  - buf_q wins because it holds the younger write;
  - raddr 0 never hits;
  - data = 0 on a miss;
  - lsu_* and ex_* inputs of the current cycle are not forwarded.
- flush_i:
  - buf_q.valid <= 0 next cycle;
  - an EX result presented in the flush cycle is dropped;
  - an LSU response in the same cycle is still written;
  - wb_q is not affected.
- busy_o = wb_q.valid | buf_q.valid.
- Reset asserted mid-operation: both entries are discarded immediately (asynchronously) and no write is issued after release.
- No combinational path from ex_valid_i to ex_ready_o.

Optional Feature:
- Macro: IBEX_RF_WB_PERF_CNT_EN.
- When defined:
  - adds output collision_cnt_o [31:0], reset 0;
  - increments by 1 in each cycle an EX result is written into buf_q;
  - saturates at 0xFFFF_FFFF.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package ibex_rf_wb_pkg holds:
  - typedef rf_wr_req_t {logic valid; logic [4:0] addr; logic [DataWidth-1:0] data} (packed, 32-bit default);
  - function rf_addr_match(addr_a, addr_b, rv32e), which excludes x0.
- One sub-module, ibex_rf_fwd_mux: instantiated once per read port; compares raddr against buf_q/wb_q and produces valid/data.

Test Plan:
- Single EX write: EX (x5, 0xDEADBEEF) at cycle 0 -> rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0xDEADBEEF at cycle 1; rf_we_o = 0 at cycle 2.
- Collision: LSU (x3, 0x11) and EX (x3, 0x22) in the same cycle -> cycle +1 writes x3 = 0x11, cycle +2 writes x3 = 0x22; ex_ready_o = 0 for exactly one cycle.
- Back-to-back LSU starvation: LSU valid for 3 cycles while buf_q holds EX (x7, 0x7) -> ex_ready_o stays 0; x7 is written the cycle after LSU drops.
- Forwarding: buf_q = (x4, 0xA), wb_q = (x4, 0xB), raddr_a_i = 4 -> fwd_a_valid_o = 1, fwd_a_data_o = 0xA; raddr_b_i = 0 -> fwd_b_valid_o = 0.
- x0 and flush:
  - EX (x0, 0xFF) -> no rf_we_o;
  - flush_i with buf_q valid -> buffered entry never written, ex_ready_o = 1 the next cycle.
- Reset mid-operation: assert rst_ni low while wb_q and buf_q are both valid -> rf_we_o = 0 immediately; no write after release; busy_o = 0.
